// File: rtl/fc_ibuf_stream.sv
// Input vector buffer for FC layers: collects NUM_CHANNELS elements per beat, replays as DAC_BITS slices.
// Optional FC_IBUF_STREAM_DBUF_EN adds a second bank so loading overlaps streaming.
module fc_ibuf_stream #(
    parameter int DATA_SIZE     = 8,
    parameter int INPUT_NEURONS = 128,
    parameter int NUM_CHANNELS  = 2,
    parameter int BUS_WIDTH     = 16,
    parameter int DAC_BITS      = 1,
    localparam int NUM_BEATS  = (INPUT_NEURONS + NUM_CHANNELS - 1) / NUM_CHANNELS,
    localparam int NUM_ADDR   = (INPUT_NEURONS + BUS_WIDTH - 1) / BUS_WIDTH,
    localparam int NUM_SLICES = (DATA_SIZE + DAC_BITS - 1) / DAC_BITS,
    localparam int BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
    localparam int ADDR_W     = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1,
    localparam int SLICE_W    = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [DATA_SIZE-1:0]          i_data [NUM_CHANNELS],
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [BUS_WIDTH*DAC_BITS-1:0] o_data,
    output logic [ADDR_W-1:0]             o_addr,
    output logic [SLICE_W-1:0]            o_slice,
    output logic                          o_last
);

`ifdef FC_IBUF_STREAM_DBUF_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    localparam int DEPTH      = (NUM_BEATS * NUM_CHANNELS > NUM_ADDR * BUS_WIDTH) ?
                                NUM_BEATS * NUM_CHANNELS : NUM_ADDR * BUS_WIDTH;
    localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLICE_BITS = NUM_SLICES * DAC_BITS;

    // A bank is in LOAD while free/filling and in STREAM once filled until its last word leaves.
    typedef enum logic {LOAD = 1'b0, STREAM = 1'b1} bank_state_t;

    bank_state_t          bank_q [NUM_BANKS];
    bank_state_t          bank_d [NUM_BANKS];
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [SLICE_W-1:0]   slice_q, slice_d;
    logic                 valid_q, valid_d;
    logic                 ready_q, ready_d;

    logic [DATA_SIZE-1:0] mem_q [NUM_BANKS][DEPTH];

    logic in_xfer, out_xfer, last_addr, last_word, load_done, stream_done;

    function automatic logic next_bank(input logic b);
        return (NUM_BANKS == 2) ? ~b : 1'b0;
    endfunction

    assign in_xfer     = i_valid && ready_q;
    assign out_xfer    = valid_q && i_ready;
    assign last_addr   = (addr_q == ADDR_W'(NUM_ADDR - 1));
    assign last_word   = last_addr && (slice_q == SLICE_W'(NUM_SLICES - 1));
    assign load_done   = in_xfer && (beat_q == BEAT_W'(NUM_BEATS - 1));
    assign stream_done = out_xfer && last_word;

    always_comb begin
        bank_d    = bank_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        beat_d    = beat_q;
        addr_d    = addr_q;
        slice_d   = slice_q;

        if (in_xfer) begin
            if (load_done) begin
                beat_d            = '0;
                bank_d[wr_bank_q] = STREAM;
                wr_bank_d         = next_bank(wr_bank_q);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        // Address is the inner loop, slice the outer; both wrap to 0 on the final word.
        if (out_xfer) begin
            if (last_addr) begin
                addr_d  = '0;
                slice_d = (slice_q == SLICE_W'(NUM_SLICES - 1)) ? '0 : slice_q + SLICE_W'(1);
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        if (stream_done) begin
            bank_d[rd_bank_q] = LOAD;
            rd_bank_d         = next_bank(rd_bank_q);
        end

        valid_d = (bank_d[rd_bank_d] == STREAM);
        ready_d = (bank_d[wr_bank_d] == LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= LOAD;
            end
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            beat_q    <= '0;
            addr_q    <= '0;
            slice_q   <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            slice_q   <= slice_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
        end
    end

    logic [IDX_W-1:0] waddr [NUM_CHANNELS];
    logic             wen   [NUM_CHANNELS];

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_wr
            int widx;
            assign widx      = int'(beat_q) * NUM_CHANNELS + gi;
            assign wen[gi]   = in_xfer && (widx < INPUT_NEURONS);
            assign waddr[gi] = IDX_W'(widx);
        end
    endgenerate

    // Storage is never reset; stale contents are only exposed after a full reload.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (wen[c]) begin
                mem_q[wr_bank_q][waddr[c]] <= i_data[c];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BUS_WIDTH; gi++) begin : g_rd
            int                    ridx;
            logic [DATA_SIZE-1:0]  elem;
            logic [SLICE_BITS-1:0] padded;
            assign ridx   = int'(addr_q) * BUS_WIDTH + gi;
            assign elem   = (ridx < INPUT_NEURONS) ? mem_q[rd_bank_q][IDX_W'(ridx)] : '0;
            assign padded = SLICE_BITS'(elem);
            assign o_data[gi*DAC_BITS +: DAC_BITS] =
                valid_q ? DAC_BITS'(padded >> (int'(slice_q) * DAC_BITS)) : '0;
        end
    endgenerate

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_addr  = addr_q;
    assign o_slice = slice_q;
    assign o_last  = valid_q && last_word;

endmodule

// File: tb/tb_fc_ibuf_stream.sv
// Scoreboard bench for fc_ibuf_stream: default instance plus a DAC_BITS=3 / 20-neuron / 3-channel instance.
module tb_fc_ibuf_stream;

    localparam int A_IN = 128, A_NC = 2, A_BW = 16, A_DB = 1;
    localparam int A_NB = 64,  A_NA = 8, A_NS = 8;
    localparam int B_IN = 20,  B_NC = 3, B_BW = 16, B_DB = 3;
    localparam int B_NB = 7,   B_NA = 2, B_NS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_i_valid, a_o_ready, a_o_valid, a_i_ready, a_o_last;
    logic [7:0]  a_i_data [A_NC];
    logic [15:0] a_o_data;
    logic [2:0]  a_o_addr, a_o_slice;

    logic        b_i_valid, b_o_ready, b_o_valid, b_i_ready, b_o_last;
    logic [7:0]  b_i_data [B_NC];
    logic [47:0] b_o_data;
    logic [0:0]  b_o_addr;
    logic [1:0]  b_o_slice;

    fc_ibuf_stream u_dut_a (
        .clk(clk), .rst(rst),
        .i_valid(a_i_valid), .o_ready(a_o_ready), .i_data(a_i_data),
        .o_valid(a_o_valid), .i_ready(a_i_ready), .o_data(a_o_data),
        .o_addr(a_o_addr), .o_slice(a_o_slice), .o_last(a_o_last)
    );

    fc_ibuf_stream #(
        .DATA_SIZE(8), .INPUT_NEURONS(B_IN), .NUM_CHANNELS(B_NC),
        .BUS_WIDTH(B_BW), .DAC_BITS(B_DB)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .i_valid(b_i_valid), .o_ready(b_o_ready), .i_data(b_i_data),
        .o_valid(b_o_valid), .i_ready(b_i_ready), .o_data(b_o_data),
        .o_addr(b_o_addr), .o_slice(b_o_slice), .o_last(b_o_last)
    );

    typedef struct {
        logic [63:0] data;
        int          addr;
        int          slice;
        bit          last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   a_xfers = 0;
    int   b_xfers = 0;
    bit   a_rand = 0;
    bit   a_hold = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [63:0] model_word(input int el[], input int nel, input int bw,
                                               input int db, input int a, input int s);
        logic [63:0] w;
        int idx, bt;
        w = '0;
        for (int l = 0; l < bw; l++) begin
            idx = a * bw + l;
            if (idx < nel) begin
                for (int k = 0; k < db; k++) begin
                    bt = s * db + k;
                    if (bt < 8) w[l*db+k] = el[idx][bt];
                end
            end
        end
        return w;
    endfunction

    task automatic push_a(input int el[]);
        exp_t e;
        for (int s = 0; s < A_NS; s++) begin
            for (int a = 0; a < A_NA; a++) begin
                e.data  = model_word(el, A_IN, A_BW, A_DB, a, s);
                e.addr  = a;
                e.slice = s;
                e.last  = (a == A_NA - 1) && (s == A_NS - 1);
                qa.push_back(e);
            end
        end
    endtask

    task automatic push_b(input int el[]);
        exp_t e;
        for (int s = 0; s < B_NS; s++) begin
            for (int a = 0; a < B_NA; a++) begin
                e.data  = model_word(el, B_IN, B_BW, B_DB, a, s);
                e.addr  = a;
                e.slice = s;
                e.last  = (a == B_NA - 1) && (s == B_NS - 1);
                qb.push_back(e);
            end
        end
    endtask

    // Called just after a rising edge; each beat is held until o_ready was high at an edge.
    task automatic load_a(input int el[], input int nbeats, input bit chk_lat, input bit chk_rdy);
        int  guard;
        bit  acc;
        for (int b = 0; b < nbeats; b++) begin
            a_i_valid = 1'b1;
            for (int c = 0; c < A_NC; c++) a_i_data[c] = 8'(el[b*A_NC+c]);
            if (chk_rdy) check("a o_ready with free bank", 64'(a_o_ready), 64'd1);
            guard = 0;
            acc   = 1'b0;
            while (!acc) begin
                acc = a_o_ready;
                @(posedge clk); #1;
                guard++;
                if (guard > 2000) begin
                    timeout("a load beat");
                    a_i_valid = 1'b0;
                    return;
                end
            end
        end
        a_i_valid = 1'b0;
        if (nbeats == A_NB) begin
            push_a(el);
            if (chk_lat) begin
                check("a latency o_valid", 64'(a_o_valid), 64'd1);
                check("a latency o_addr", 64'(a_o_addr), 64'd0);
                check("a latency o_slice", 64'(a_o_slice), 64'd0);
            end
        end
    endtask

    task automatic load_b(input int el[]);
        int guard;
        bit acc;
        for (int b = 0; b < B_NB; b++) begin
            b_i_valid = 1'b1;
            for (int c = 0; c < B_NC; c++)
                b_i_data[c] = (b*B_NC + c < B_IN) ? 8'(el[b*B_NC+c]) : 8'hEE;
            guard = 0;
            acc   = 1'b0;
            while (!acc) begin
                acc = b_o_ready;
                @(posedge clk); #1;
                guard++;
                if (guard > 2000) begin
                    timeout("b load beat");
                    b_i_valid = 1'b0;
                    return;
                end
            end
        end
        b_i_valid = 1'b0;
        push_b(el);
        check("b latency o_valid", 64'(b_o_valid), 64'd1);
    endtask

    task automatic drain_a(input string name);
        int guard = 0;
        while (qa.size() > 0) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 5000) begin
                timeout(name);
                qa.delete();
                return;
            end
        end
    endtask

    task automatic drain_b();
        int guard = 0;
        while (qb.size() > 0) begin
            @(posedge clk); #1;
            guard++;
            if (guard > 5000) begin
                timeout("b drain");
                qb.delete();
                return;
            end
        end
    endtask

    initial begin
        a_i_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            a_i_ready = a_hold ? 1'b0 : (a_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    logic        a_stall_prev = 1'b0, a_last_prev = 1'b0;
    logic [15:0] a_data_prev;
    logic [2:0]  a_addr_prev, a_slice_prev;
    logic        a_olast_prev;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            a_stall_prev = 1'b0;
            a_last_prev  = 1'b0;
        end else begin
            if (a_stall_prev) begin
                check("a stall o_valid", 64'(a_o_valid), 64'd1);
                check("a stall o_data", 64'(a_o_data), 64'(a_data_prev));
                check("a stall o_addr", 64'(a_o_addr), 64'(a_addr_prev));
                check("a stall o_slice", 64'(a_o_slice), 64'(a_slice_prev));
                check("a stall o_last", 64'(a_o_last), 64'(a_olast_prev));
            end
`ifdef FC_IBUF_STREAM_DBUF_EN
            if (a_last_prev && qa.size() > 0) check("a no bubble", 64'(a_o_valid), 64'd1);
`endif
            if (a_o_valid) begin
`ifndef FC_IBUF_STREAM_DBUF_EN
                check("a o_ready in stream", 64'(a_o_ready), 64'd0);
`endif
                if (a_i_ready) begin
                    if (qa.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL a unexpected word: addr %0d slice %0d data %0h, expected none",
                                 a_o_addr, a_o_slice, a_o_data);
                    end else begin
                        e = qa.pop_front();
                        check("a o_data", 64'(a_o_data), e.data);
                        check("a o_addr", 64'(a_o_addr), 64'(e.addr));
                        check("a o_slice", 64'(a_o_slice), 64'(e.slice));
                        check("a o_last", 64'(a_o_last), 64'(e.last));
                    end
                    a_xfers++;
                end
            end else begin
                check("a idle o_data", 64'(a_o_data), 64'd0);
            end
            a_stall_prev = a_o_valid && !a_i_ready;
            a_last_prev  = a_o_valid && a_i_ready && a_o_last;
            a_data_prev  = a_o_data;
            a_addr_prev  = a_o_addr;
            a_slice_prev = a_o_slice;
            a_olast_prev = a_o_last;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b_o_valid && b_i_ready) begin
                if (qb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b unexpected word: data %0h, expected none", b_o_data);
                end else begin
                    e = qb.pop_front();
                    check("b o_data", 64'(b_o_data), e.data);
                    check("b o_addr", 64'(b_o_addr), 64'(e.addr));
                    check("b o_slice", 64'(b_o_slice), 64'(e.slice));
                    check("b o_last", 64'(b_o_last), 64'(e.last));
                end
                b_xfers++;
            end else if (!b_o_valid) begin
                check("b idle o_data", 64'(b_o_data), 64'd0);
            end
        end
    end

    initial begin
        int v1[], v2[], v3[], v4[], vb1[], vb2[];
        int start;
        v1 = new[A_IN]; v2 = new[A_IN]; v3 = new[A_IN]; v4 = new[A_IN];
        vb1 = new[B_IN]; vb2 = new[B_IN];
        for (int n = 0; n < A_IN; n++) begin
            v1[n] = n;
            v2[n] = (n * 37 + 11) & 255;
            v3[n] = 255 - n;
            v4[n] = n ^ 8'h5A;
        end
        for (int n = 0; n < B_IN; n++) begin
            vb1[n] = 8'hFF;
            vb2[n] = (n * 13 + 7) & 255;
        end

        rst = 1'b1;
        a_i_valid = 1'b0;
        b_i_valid = 1'b0;
        b_i_ready = 1'b1;
        for (int c = 0; c < A_NC; c++) a_i_data[c] = '0;
        for (int c = 0; c < B_NC; c++) b_i_data[c] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset o_valid", 64'(a_o_valid), 64'd0);
        check("reset o_ready", 64'(a_o_ready), 64'd0);
        check("reset o_data", 64'(a_o_data), 64'd0);
        check("reset o_addr", 64'(a_o_addr), 64'd0);
        check("reset o_slice", 64'(a_o_slice), 64'd0);
        check("reset o_last", 64'(a_o_last), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post-reset o_ready", 64'(a_o_ready), 64'd1);

        // Ramp vector, always ready.
        start = a_xfers;
        load_a(v1, A_NB, 1'b1, 1'b0);
        check("a word0 hand value", 64'(a_o_data), 64'h0000_0000_0000_AAAA);
        drain_a("a drain ramp");
        check("a ramp transfer count", 64'(a_xfers - start), 64'd64);
        check("a done o_valid", 64'(a_o_valid), 64'd0);
        check("a done o_ready", 64'(a_o_ready), 64'd1);

        // Random backpressure.
        a_rand = 1'b1;
        start = a_xfers;
        load_a(v2, A_NB, 1'b1, 1'b0);
        drain_a("a drain random");
        a_rand = 1'b0;
        check("a random transfer count", 64'(a_xfers - start), 64'd64);

        // Reset mid-load, then a full vector.
        load_a(v3, 30, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("a after mid-load reset o_valid", 64'(a_o_valid), 64'd0);
        start = a_xfers;
        load_a(v4, A_NB, 1'b1, 1'b0);
        drain_a("a drain after reset");
        check("a post-reset transfer count", 64'(a_xfers - start), 64'd64);

        // Reset mid-stream discards the rest of the vector.
        load_a(v1, A_NB, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        qa.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("a after mid-stream reset o_valid", 64'(a_o_valid), 64'd0);
        check("a after mid-stream reset o_ready", 64'(a_o_ready), 64'd1);

`ifdef FC_IBUF_STREAM_DBUF_EN
        // Two vectors queued while output is stalled, then released back to back.
        a_hold = 1'b1;
        @(posedge clk); #1;
        start = a_xfers;
        load_a(v2, A_NB, 1'b1, 1'b1);
        load_a(v4, A_NB, 1'b0, 1'b1);
        @(posedge clk); #1;
        check("a both banks full o_ready", 64'(a_o_ready), 64'd0);
        a_hold = 1'b0;
        drain_a("a drain dbuf");
        check("a dbuf transfer count", 64'(a_xfers - start), 64'd128);
        // Overlapped load while streaming.
        start = a_xfers;
        load_a(v3, A_NB, 1'b1, 1'b0);
        load_a(v1, A_NB, 1'b0, 1'b0);
        drain_a("a drain overlap");
        check("a overlap transfer count", 64'(a_xfers - start), 64'd128);
`endif

        // Partial top slice and dropped lanes.
        start = b_xfers;
        load_b(vb1);
        check("b word0 hand value", 64'(b_o_data), 64'h0000_FFFF_FFFF_FFFF);
        drain_b();
        load_b(vb2);
        drain_b();
        check("b transfer count", 64'(b_xfers - start), 64'd12);

        repeat (5) @(posedge clk);
        #1;
        check("a final o_valid", 64'(a_o_valid), 64'd0);
        check("b final o_valid", 64'(b_o_valid), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
